// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU function codes, MIPS32
// opcode/funct encodings, FSM states and immediate-extension helpers.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_MUL = 3'b101
  } alu_func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } issue_state_e;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b000010;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational decode of one MIPS32 instruction into ALU function, operands,
// a MUL flag (selects the longer settle time) and an illegal-instruction flag.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic [15:0] i_imm,
  output alu_func_e   o_alufunc,
  output logic [31:0] o_in1,
  output logic [31:0] o_in2,
  output logic        o_is_mul,
  output logic        o_illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves
    // one unassigned, which would otherwise infer a latch.
    o_alufunc = ALU_ADD;
    o_in1     = i_rs_val;
    o_in2     = i_rt_val;
    o_is_mul  = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_alufunc = ALU_ADD;
          FN_SUB:  o_alufunc = ALU_SUB;
          FN_AND:  o_alufunc = ALU_AND;
          FN_OR:   o_alufunc = ALU_OR;
          FN_SLT:  o_alufunc = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        if (i_funct == FN_MUL) begin
          o_alufunc = ALU_MUL;
          o_is_mul  = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_ADDI, OP_LW, OP_SW: begin
        o_alufunc = ALU_ADD;
        o_in2     = sext16(i_imm);
      end
      OP_SLTI: begin
        // SLT compares unsigned inside the ALU; only the immediate is sign-extended.
        o_alufunc = ALU_SLT;
        o_in2     = sext16(i_imm);
      end
      OP_ANDI: begin
        o_alufunc = ALU_AND;
        o_in2     = zext16(i_imm);
      end
      OP_ORI: begin
        o_alufunc = ALU_OR;
        o_in2     = zext16(i_imm);
      end
      OP_BEQ:  o_alufunc = ALU_SUB;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU initiator: accepts a decoded instruction, drives held operands to an external
// combinational ALU, waits a settle time (longer for MUL) and returns the result.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int MUL_CYCLES    = 3,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  output logic [2:0]  alufunc,
  output logic [31:0] in1,
  output logic [31:0] in2,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err
);

  alu_func_e    w_alufunc;
  logic [31:0]  w_in1;
  logic [31:0]  w_in2;
  logic         w_is_mul;
  logic         w_illegal;

  issue_state_e r_state;
  alu_func_e    r_alufunc;
  logic [31:0]  r_in1;
  logic [31:0]  r_in2;
  logic [CNT_W-1:0] r_cnt;
  logic         r_rsp_valid;
  logic [31:0]  r_rsp_result;
  logic         r_rsp_err;

  alu_op_decode u_decode (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .i_rs_val  (rs_val),
    .i_rt_val  (rt_val),
    .i_imm     (imm),
    .o_alufunc (w_alufunc),
    .o_in1     (w_in1),
    .o_in2     (w_in2),
    .o_is_mul  (w_is_mul),
    .o_illegal (w_illegal)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_alufunc    <= ALU_ADD;
      r_in1        <= '0;
      r_in2        <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_illegal) begin
              // Operands stay untouched so the ALU inputs never glitch on a reject.
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_alufunc <= w_alufunc;
              r_in1     <= w_in1;
              r_in2     <= w_in2;
              r_cnt     <= w_is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(SETTLE_CYCLES);
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_result <= alu_out;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign alufunc    = r_alufunc;
  assign in1        = r_in1;
  assign in2        = r_in2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Table-driven bench for alu_issue_ctrl with a behavioural ALU on alu_out, plus
// hand-written sequences for reset and abort-during-MUL.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;
  logic [2:0]  alufunc;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE_CYCLES(1), .MUL_CYCLES(3), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct      (funct),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .imm        (imm),
    .alufunc    (alufunc),
    .in1        (in1),
    .in2        (in2),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  // Combinational ALU the unit talks to; SLT is unsigned, MUL keeps the low word.
  always_comb begin
    alu_out = 32'h0;
    case (alufunc)
      3'b000:  alu_out = in1 + in2;
      3'b001:  alu_out = in1 - in2;
      3'b010:  alu_out = in1 & in2;
      3'b011:  alu_out = in1 | in2;
      3'b100:  alu_out = {31'h0, in1 < in2};
      3'b101:  alu_out = in1 * in2;
      default: alu_out = 32'h0;
    endcase
  end

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] im;
    logic [2:0]  e_func;
    logic [31:0] e_in1;
    logic [31:0] e_in2;
    logic [31:0] e_res;
    logic        e_err;
    int          e_lat;
    int          hold;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                              input logic [2:0] e_func, input logic [31:0] e_in1,
                              input logic [31:0] e_in2, input logic [31:0] e_res,
                              input logic e_err, input int e_lat, input int hold);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.im = im;
    v.e_func = e_func; v.e_in1 = e_in1; v.e_in2 = e_in2; v.e_res = e_res;
    v.e_err = e_err; v.e_lat = e_lat; v.hold = hold;
    return v;
  endfunction

  // One transaction: accept, measure latency, check operands/result, optionally
  // hold off rsp_ready, then handshake and confirm the return to IDLE.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    check({v.name, " req_ready before"}, 32'(req_ready), 32'd1);
    opcode = v.op; funct = v.fn; rs_val = v.rs; rt_val = v.rt; imm = v.im;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) lat = c;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.e_lat));
    check({v.name, " alufunc"}, 32'(alufunc), 32'(v.e_func));
    check({v.name, " in1"}, in1, v.e_in1);
    check({v.name, " in2"}, in2, v.e_in2);
    check({v.name, " result"}, rsp_result, v.e_res);
    check({v.name, " err"}, 32'(rsp_err), 32'(v.e_err));
    check({v.name, " req_ready in RESP"}, 32'(req_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check({v.name, " held valid"}, 32'(rsp_valid), 32'd1);
      check({v.name, " held result"}, rsp_result, v.e_res);
      check({v.name, " held err"}, 32'(rsp_err), 32'(v.e_err));
      check({v.name, " held req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({v.name, " valid after handshake"}, 32'(rsp_valid), 32'd0);
    check({v.name, " idle after handshake"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = mk("add",      6'h00, 6'h20, 32'd5,        32'd7,    16'h0000, 3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 2, 0);
    vecs[1]  = mk("addi",     6'h08, 6'h00, 32'd10,       32'h55,   16'hFFFF, 3'b000, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 2, 0);
    vecs[2]  = mk("andi",     6'h0C, 6'h00, 32'hFFFFFFFF, 32'h55,   16'hF0F0, 3'b010, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0, 1'b0, 2, 0);
    vecs[3]  = mk("mul",      6'h1C, 6'h02, 32'd6,        32'd7,    16'h0000, 3'b101, 32'd6,        32'd7,        32'd42,       1'b0, 4, 0);
    vecs[4]  = mk("mul_wrap", 6'h1C, 6'h02, 32'h10000,    32'h10000,16'h0000, 3'b101, 32'h10000,    32'h10000,    32'd0,        1'b0, 4, 0);
    vecs[5]  = mk("sub_bp",   6'h00, 6'h22, 32'd3,        32'd5,    16'h0000, 3'b001, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 2, 3);
    vecs[6]  = mk("ill_op",   6'h3F, 6'h20, 32'hDEAD,     32'hBEEF, 16'h1234, 3'b001, 32'd3,        32'd5,        32'd0,        1'b1, 1, 2);
    vecs[7]  = mk("add2",     6'h00, 6'h20, 32'd1,        32'd2,    16'h0000, 3'b000, 32'd1,        32'd2,        32'd3,        1'b0, 2, 0);
    vecs[8]  = mk("slt_u",    6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,    16'h0000, 3'b100, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 2, 0);
    vecs[9]  = mk("slti",     6'h0A, 6'h00, 32'd5,        32'h55,   16'h8000, 3'b100, 32'd5,        32'hFFFF8000, 32'd1,        1'b0, 2, 0);
    vecs[10] = mk("ori",      6'h0D, 6'h00, 32'h12340000, 32'h55,   16'h8001, 3'b011, 32'h12340000, 32'h00008001, 32'h12348001, 1'b0, 2, 0);
    vecs[11] = mk("lw",       6'h23, 6'h00, 32'h100,      32'h55,   16'hFFFC, 3'b000, 32'h100,      32'hFFFFFFFC, 32'h000000FC, 1'b0, 2, 0);
    vecs[12] = mk("beq",      6'h04, 6'h00, 32'd9,        32'd9,    16'h0003, 3'b001, 32'd9,        32'd9,        32'd0,        1'b0, 2, 0);
    vecs[13] = mk("ill_fn",   6'h00, 6'h00, 32'h77,       32'h88,   16'h0000, 3'b001, 32'd9,        32'd9,        32'd0,        1'b1, 1, 0);
    vecs[14] = mk("ill_sp2",  6'h1C, 6'h00, 32'h77,       32'h88,   16'h0000, 3'b001, 32'd9,        32'd9,        32'd0,        1'b1, 1, 0);
    vecs[15] = mk("sw",       6'h2B, 6'h00, 32'h20,       32'h55,   16'h0004, 3'b000, 32'h20,       32'h4,        32'h24,       1'b0, 2, 0);
    vecs[16] = mk("or",       6'h00, 6'h25, 32'hF0,       32'h0F,   16'h0000, 3'b011, 32'hF0,       32'h0F,       32'hFF,       1'b0, 2, 0);

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset alufunc", 32'(alufunc), 32'd0);
    check("reset in1", in1, 32'd0);
    check("reset in2", in2, 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Abort a MUL while it is settling; no response may ever appear for it.
    @(negedge clk);
    opcode = 6'h1C; funct = 6'h02; rs_val = 32'd6; rt_val = 32'd7; imm = '0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort alufunc latched", 32'(alufunc), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("abort req_ready in rst", 32'(req_ready), 32'd0);
    check("abort alufunc", 32'(alufunc), 32'd0);
    check("abort in1", in1, 32'd0);
    check("abort in2", in2, 32'd0);
    check("abort rsp_result", rsp_result, 32'd0);
    check("abort rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort no rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort idle", 32'(req_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
